// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle RISC-V ALU.
//   - 4-bit opcode encodings (ADD/SUB/LUI/OR keep their legacy codes)
//   - FSM state encoding used by alu_multicycle
//   - is_multicycle(): true for opcodes that need the iterative datapath
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_LUI  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REM  = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // MUL and the four divide-class opcodes occupy the top of the code space.
    function automatic logic is_multicycle(input logic [3:0] op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : load dividend/divisor and begin (WIDTH iterations)
//   dividend       : unsigned dividend
//   divisor        : unsigned divisor (must be non-zero; caller filters zero)
//   done           : one-cycle pulse once quotient/remainder are final
//   quotient       : unsigned quotient
//   remainder      : unsigned remainder
module alu_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] den;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;

    // The quotient register doubles as the dividend shift register: its MSB
    // is shifted into the partial remainder each step. Because the partial
    // remainder is always below 2*divisor, the top bit of the trial
    // subtraction is exactly the borrow (partial < divisor).
    assign partial = {remainder, quotient[WIDTH-1]};
    assign diff    = partial - {1'b0, den};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            den       <= '0;
            cnt       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                remainder <= '0;
                den       <= divisor;
                cnt       <= '0;
                running   <= 1'b1;
            end else if (running) begin
                if (diff[WIDTH]) begin
                    remainder <= partial[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b0};
                end else begin
                    remainder <= diff[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b1};
                end
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: parametrised RISC-V ALU with single-cycle and iterative ops.
//   clk, reset       : clock, asynchronous active-low reset
//   start_i          : request, accepted only while busy_o is low
//   ALU_Operation_i  : 4-bit opcode (see alu_pkg)
//   A_i, B_i         : operands, captured at the accept edge
//   busy_o           : high while a MUL/DIV-class op is in flight
//   done_o           : one-cycle pulse when ALU_Result_o/Zero_o update
//   Zero_o           : registered (ALU_Result_o == 0)
//   ALU_Result_o     : registered result, held until the next done_o
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             Zero_o,
    output logic [WIDTH-1:0] ALU_Result_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             accept;
    logic             div_class;
    logic             signed_div;
    logic             div_zero;
    logic             sgn_ovf;
    logic             fast;
    logic             div_start;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] fast_result;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_next;
    logic [CNT_W-1:0] iter_cnt;
    logic             negate;
    logic             want_rem;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] fix_raw;
    logic [WIDTH-1:0] fix_result;

    assign accept     = start_i && !busy_o;
    assign div_class  = (ALU_Operation_i[3:2] == 2'b11);
    assign signed_div = (ALU_Operation_i == OP_DIV) || (ALU_Operation_i == OP_REM);
    assign div_zero   = (B_i == '0);
    assign sgn_ovf    = signed_div && (A_i == MOST_NEG) && (B_i == '1);
    // Divide special cases resolve at accept time, like the simple ops.
    assign fast       = !is_multicycle(ALU_Operation_i) || (div_class && (div_zero || sgn_ovf));
    assign div_start  = accept && div_class && !fast;
    assign shamt      = B_i[SHAMT_W-1:0];
    assign a_mag      = (signed_div && A_i[WIDTH-1]) ? -A_i : A_i;
    assign b_mag      = (signed_div && B_i[WIDTH-1]) ? -B_i : B_i;
    assign mul_next   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign fix_raw    = want_rem ? div_rem : div_quot;
    assign fix_result = negate ? -fix_raw : fix_raw;

    // Result for every op that completes at the accept edge, including the
    // divide-by-zero and signed-overflow cases of the divide class.
    always_comb begin
        fast_result = '0;
        case (ALU_Operation_i)
            OP_ADD:  fast_result = A_i + B_i;
            OP_SUB:  fast_result = A_i - B_i;
            OP_LUI:  fast_result = B_i;
            OP_OR:   fast_result = A_i | B_i;
            OP_AND:  fast_result = A_i & B_i;
            OP_XOR:  fast_result = A_i ^ B_i;
            OP_SLL:  fast_result = A_i << shamt;
            OP_SRL:  fast_result = A_i >> shamt;
            OP_SRA:  fast_result = $unsigned($signed(A_i) >>> shamt);
            OP_SLT:  fast_result = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OP_SLTU: fast_result = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
            OP_DIV, OP_DIVU: fast_result = div_zero ? '1 : A_i;
            OP_REM, OP_REMU: fast_result = div_zero ? A_i : '0;
            default: fast_result = '0;
        endcase
    end

    alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Control FSM. DONE behaves like IDLE for accepting a new request, so
    // single-cycle ops can issue back to back; after a multi-cycle op busy_o
    // is still high during DONE, which blocks acceptance for that one cycle.
    // The shared iteration counter paces both MUL and DIV so that the state
    // leaves DIV on the same edge the divider produces its last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            Zero_o       <= 1'b1;
            ALU_Result_o <= '0;
            mul_acc      <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            iter_cnt     <= '0;
            negate       <= 1'b0;
            want_rem     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                    if (accept) begin
                        iter_cnt <= '0;
                        if (fast) begin
                            ALU_Result_o <= fast_result;
                            Zero_o       <= (fast_result == '0);
                            done_o       <= 1'b1;
                            state        <= ST_DONE;
                        end else if (ALU_Operation_i == OP_MUL) begin
                            mul_acc    <= '0;
                            mul_mcand  <= A_i;
                            mul_mplier <= B_i;
                            busy_o     <= 1'b1;
                            state      <= ST_MUL;
                        end else begin
                            // Quotient is negative when signs differ; the
                            // remainder follows the sign of the dividend.
                            want_rem <= ALU_Operation_i[1];
                            negate   <= signed_div &&
                                        (ALU_Operation_i[1] ? A_i[WIDTH-1]
                                                            : (A_i[WIDTH-1] ^ B_i[WIDTH-1]));
                            busy_o   <= 1'b1;
                            state    <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    iter_cnt   <= iter_cnt + 1'b1;
                    mul_acc    <= mul_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    if (iter_cnt == CNT_W'(WIDTH - 1)) begin
                        ALU_Result_o <= mul_next;
                        Zero_o       <= (mul_next == '0);
                        done_o       <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (div_done) begin
                        ALU_Result_o <= fix_result;
                        Zero_o       <= (fix_result == '0);
                        done_o       <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32) plus a
// few directed checks on a WIDTH=8 instance.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic        zero_o;
    logic [31:0] result_o;

    logic        s8_start;
    logic [3:0]  s8_op;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic        s8_busy;
    logic        s8_done;
    logic        s8_zero;
    logic [7:0]  s8_result;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (op_i),
        .A_i             (a_i),
        .B_i             (b_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .Zero_o          (zero_o),
        .ALU_Result_o    (result_o)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .start_i         (s8_start),
        .ALU_Operation_i (s8_op),
        .A_i             (s8_a),
        .B_i             (s8_b),
        .busy_o          (s8_busy),
        .done_o          (s8_done),
        .Zero_o          (s8_zero),
        .ALU_Result_o    (s8_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour straight from the opcode definitions.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned sh;
        logic [63:0] prod;
        sa   = a;
        sb   = b;
        sh   = b % 32;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_LUI:  return b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'(sa >>> sh);
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:  return prod[31:0];
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op < OP_MUL) return 1;
        if (op == OP_MUL) return 33;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        n_tests++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, required, cyc);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN32;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Waits for the DUT to be free (poking ignored starts meanwhile), then
    // drives one request and records what should come back and when.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (busy_o && guard < 200) begin
            start_i = ($urandom_range(0, 3) == 0);
            op_i    = 4'($urandom_range(0, 15));
            a_i     = $urandom;
            b_i     = $urandom;
            guard++;
            @(negedge clk);
        end
        if (busy_o) begin
            n_tests++;
            n_fail++;
            start_i = 1'b0;
            $display("[TB] FAIL accept_timeout: busy_o=%0b after %0d cycles, expected 0", busy_o, guard);
        end else begin
            start_i = 1'b1;
            op_i    = op;
            a_i     = a;
            b_i     = b;
            e.op    = op;
            e.res   = ref_result(op, a, b);
            e.cyc   = cyc + ref_latency(op, a, b);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    task automatic check8(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat);
        int c0;
        int waited = 0;
        @(negedge clk);
        s8_start = 1'b1;
        s8_op    = op;
        s8_a     = a;
        s8_b     = b;
        c0       = cyc;
        @(negedge clk);
        s8_start = 1'b0;
        while (!s8_done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s8_done) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: done_o=0 after %0d cycles, expected 1", name, waited);
        end else begin
            checkOutput({name, "_result"}, {24'd0, s8_result}, {24'd0, exp_res});
            checkOutput({name, "_zero"}, {31'd0, s8_zero}, {31'd0, (exp_res == 8'd0)});
            checkOutput({name, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (reset && done_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: done_o=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("result_op%0d", e.op), result_o, e.res);
                checkOutput($sformatf("zero_op%0d", e.op), {31'd0, zero_o}, {31'd0, (e.res == 0)});
                checkOutput($sformatf("latency_op%0d", e.op), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int guard;
        reset    = 1'b0;
        start_i  = 1'b0;
        op_i     = '0;
        a_i      = '0;
        b_i      = '0;
        s8_start = 1'b0;
        s8_op    = '0;
        s8_a     = '0;
        s8_b     = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_done", {31'd0, done_o}, 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("reset_zero", {31'd0, zero_o}, 32'd1);
        reset = 1'b1;

        // Abort a divide with reset five cycles in.
        applyStimulus(OP_ADD, 32'd10, 32'd20);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(5);
        reset = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("abort_result", result_o, 32'd0);
        checkOutput("abort_zero", {31'd0, zero_o}, 32'd1);
        idle(2);
        reset = 1'b1;
        idle(40);
        applyStimulus(OP_ADD, 32'd3, 32'd4);

        applyStimulus(OP_SUB, 32'd5, 32'd5);
        applyStimulus(OP_SRA, MIN32, 32'd4);
        applyStimulus(OP_SLTU, 32'd1, 32'hFFFF_FFFF);

        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'd3);
        idle(9);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OP_ADD;
        a_i     = 32'd1;
        b_i     = 32'd1;
        checkOutput("busy_during_mul", {31'd0, busy_o}, 32'd1);
        idle(1);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_DIVU, 32'd7, 32'd2);
        applyStimulus(OP_DIVU, 32'd9, 32'd0);
        applyStimulus(OP_REMU, 32'd9, 32'd0);
        applyStimulus(OP_DIV, MIN32, 32'hFFFF_FFFF);
        applyStimulus(OP_REM, MIN32, 32'hFFFF_FFFF);

        for (int i = 0; i < 80; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
            idle($urandom_range(0, 2));
        end
        idle(1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        check8("w8_mul", OP_MUL, 8'h10, 8'h10, 8'h00, 9);
        check8("w8_sll", OP_SLL, 8'h01, 8'h0B, 8'h08, 1);
        check8("w8_div", OP_DIV, 8'hF9, 8'h02, 8'hFD, 10);
        check8("w8_remu", OP_REMU, 8'd200, 8'd7, 8'd4, 10);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
